// File: rtl/i2c_master_write.sv
// Single-byte I2C write master: START, address byte, ACK, data byte, ACK, STOP.
// SDA is open-drain (sda_oe pulls low); scl and sda_oe are registered.
module i2c_master_write #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] q_cnt_q, q_cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          ack_err_q, ack_err_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;

  logic q_wrap;
  logic slot_end;
  logic ack_sample;

  assign q_wrap     = (q_cnt_q == Q_LAST);
  assign slot_end   = q_wrap && (phase_q == 2'd3);
  assign ack_sample = ((state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK)) &&
                      (phase_q == 2'd3) && (q_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    q_cnt_d   = q_cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && ready_q) begin
        addr_d    = addr;
        data_d    = wdata;
        ack_err_d = 1'b0;
        ready_d   = 1'b0;
        q_cnt_d   = '0;
        phase_d   = 2'd0;
        bit_d     = 3'd0;
        state_d   = S_START;
      end
    end else begin
      if (q_wrap) begin
        q_cnt_d = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        q_cnt_d = q_cnt_q + QW'(1);
      end

      if (ack_sample && sda_i) begin
        ack_err_d = 1'b1;
      end

      if (slot_end) begin
        unique case (state_q)
          S_START: begin
            state_d = S_ADDR;
            bit_d   = 3'd7;
          end
          S_ADDR: begin
            if (bit_q == 3'd0) state_d = S_ADDR_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
          // ack_err was cleared at accept, so here it reflects only the address ACK
          S_ADDR_ACK: begin
            if (ack_err_q) begin
              state_d = S_STOP;
            end else begin
              state_d = S_DATA;
              bit_d   = 3'd7;
            end
          end
          S_DATA: begin
            if (bit_q == 3'd0) state_d = S_DATA_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
          S_DATA_ACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Outputs are derived from the next state so the registered pins line up with it
    scl_d = 1'b1;
    oe_d  = 1'b0;
    unique case (state_d)
      S_START: begin
        scl_d = ~phase_d[1];
        oe_d  = 1'b1;
      end
      S_ADDR: begin
        scl_d = phase_d[1];
        oe_d  = ~addr_d[bit_d];
      end
      S_DATA: begin
        scl_d = phase_d[1];
        oe_d  = ~data_d[bit_d];
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        scl_d = phase_d[1];
        oe_d  = 1'b0;
      end
      S_STOP: begin
        scl_d = phase_d[1];
        oe_d  = (phase_d != 2'd3);
      end
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      q_cnt_q   <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ack_err_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_cnt_q   <= q_cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      oe_q      <= oe_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl     = scl_q;
  assign sda_oe  = oe_q;

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: bus monitor with ACK-driving slave model and a
// token scoreboard (START / byte+ack / STOP) fed by the directed stimulus.
module tb_i2c_master_write;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic       ack_err;
  logic       scl;
  logic       sda_oe;
  logic       sda_line;
  logic       slave_pull;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int obs_q[$];

  logic       nack_addr = 1'b0;
  logic       nack_data = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       cur_sda;
  int         nbits = 0;
  int         byte_idx = 0;
  logic [7:0] shreg = '0;
  logic [7:0] first_byte = '0;
  logic [7:0] slave_rx = '0;
  int         done_cnt = 0;

  assign sda_line = ~(sda_oe | slave_pull);

  i2c_master_write #(.CLK_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .done   (done),
    .ack_err(ack_err),
    .scl    (scl),
    .sda_oe (sda_oe),
    .sda_i  (sda_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial slave_pull = 1'b0;

  // Bus monitor and slave: START = -1, STOP = -2, byte token = byte + 256*sampled_ack_bit
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      nbits      = 0;
      byte_idx   = 0;
      slave_pull = 1'b0;
      obs_q.delete();
    end else begin
      cur_sda = ~(sda_oe | slave_pull);
      if (prev_scl && scl && prev_sda && !cur_sda) begin
        obs_q.push_back(-1);
        nbits      = 0;
        byte_idx   = 0;
        slave_pull = 1'b0;
      end else if (prev_scl && scl && !prev_sda && cur_sda) begin
        obs_q.push_back(-2);
        slave_pull = 1'b0;
      end else if (!prev_scl && scl) begin
        if (nbits < 8) begin
          shreg = {shreg[6:0], cur_sda};
          nbits++;
        end else begin
          obs_q.push_back(int'(shreg) + (cur_sda ? 256 : 0));
          if (byte_idx == 0) first_byte = shreg;
          else if (byte_idx == 1 && first_byte[7:1] == 7'd0 && !cur_sda) slave_rx = shreg;
          byte_idx++;
          nbits = 0;
        end
      end else if (prev_scl && !scl) begin
        slave_pull = (nbits == 8) && !((byte_idx == 0) ? nack_addr : nack_data);
      end
    end
    prev_scl = scl;
    prev_sda = ~(sda_oe | slave_pull);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] d, input bit na, input bit nd);
    exp_q.push_back(-1);
    exp_q.push_back(int'(a) + (na ? 256 : 0));
    if (!na) exp_q.push_back(int'(d) + (nd ? 256 : 0));
    exp_q.push_back(-2);
  endtask

  task automatic check_frame(input string tag);
    int e;
    int o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -99;
      chk({tag, ".token"}, o, e);
    end
    chk({tag, ".extra_tokens"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (done !== 1'b1 && cnt < 2000);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input bit na, input bit nd, input int exp_cyc);
    int cnt;
    @(negedge clk);
    addr      = a;
    wdata     = d;
    nack_addr = na;
    nack_data = nd;
    start     = 1'b1;
    push_frame(a, d, na, nd);
    chk({tag, ".ready_pre"}, ready, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    addr  = ~a;
    wdata = ~d;
    chk({tag, ".ready_busy"}, ready, 0);
    chk({tag, ".ack_err_clr"}, ack_err, 0);
    wait_done(cnt);
    chk({tag, ".latency"}, cnt, exp_cyc);
    chk({tag, ".ack_err"}, ack_err, (na || nd) ? 1 : 0);
    chk({tag, ".idle_scl"}, scl, 1);
    chk({tag, ".idle_sda_oe"}, sda_oe, 0);
    chk({tag, ".ready_done"}, ready, 1);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, done, 0);
    check_frame(tag);
  endtask

  initial begin
    int cnt;
    int d0;
    rst   = 1'b0;
    start = 1'b0;
    addr  = '0;
    wdata = '0;

    // 1: asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst.scl", scl, 1);
    chk("rst.sda_oe", sda_oe, 0);
    chk("rst.ready", ready, 1);
    chk("rst.done", done, 0);
    chk("rst.ack_err", ack_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 2: normal write to slave address 0
    do_frame("wr_a5", 8'h00, 8'hA5, 1'b0, 1'b0, 320);
    chk("wr_a5.slave_rx", slave_rx, 8'hA5);

    // 3: address NACK
    do_frame("nack_addr", 8'h00, 8'h77, 1'b1, 1'b0, 176);

    // 4: data NACK, then a clean frame clears ack_err
    do_frame("nack_data", 8'h3C, 8'hFF, 1'b0, 1'b1, 320);
    do_frame("after_nack", 8'h3C, 8'h11, 1'b0, 1'b0, 320);

    // 5: back-to-back with start held high
    @(negedge clk);
    nack_addr = 1'b0;
    nack_data = 1'b0;
    addr  = 8'h00;
    wdata = 8'h01;
    start = 1'b1;
    push_frame(8'h00, 8'h01, 1'b0, 1'b0);
    push_frame(8'h00, 8'h80, 1'b0, 1'b0);
    d0 = done_cnt;
    @(posedge clk);
    #1 wdata = 8'h80;
    wait_done(cnt);
    chk("b2b.latency1", cnt, 320);
    chk("b2b.ready_at_done", ready, 1);
    chk("b2b.idle_scl", scl, 1);
    chk("b2b.idle_sda_oe", sda_oe, 0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b.ready_busy2", ready, 0);
    chk("b2b.start_sda_oe", sda_oe, 1);
    wait_done(cnt);
    chk("b2b.latency2", cnt, 320);
    @(posedge clk);
    #1;
    chk("b2b.done_count", done_cnt - d0, 2);
    check_frame("b2b");

    // 6: reset in the middle of data bit 3, then a normal frame
    @(negedge clk);
    addr  = 8'h00;
    wdata = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (228) @(posedge clk);
    #2;
    chk("midrst.pre_scl", scl, 0);
    chk("midrst.pre_sda_oe", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("midrst.scl", scl, 1);
    chk("midrst.sda_oe", sda_oe, 0);
    chk("midrst.ready", ready, 1);
    chk("midrst.done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    do_frame("post_rst", 8'h00, 8'h5A, 1'b0, 1'b0, 320);
    chk("post_rst.slave_rx", slave_rx, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
